// File: rtl/sap_pkg.sv
// Shared definitions for the SAP RAM block: controller state encoding and
// default widths for the SAP-1 build.
package sap_pkg;

   localparam int SAP_ADDR_W = 4;
   localparam int SAP_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_PROG  = 2'd2
   } sap_state_e;

endpackage

// File: rtl/sap_ram_array.sv
// Plain DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module sap_ram_array #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sap_ram.sv
// SAP RAM with MAR, tristate bus driver, post-reset clear sweep and a
// handshaked sequential program-load mode.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zero one location per cycle from ptr 0 to DEPTH-1, busy = 1
// ST_RUN   | normal CPU access: MAR load, write strobe, combinational read
// ST_PROG  | loader fills memory at ptr on prog_valid, bus forced Z
module sap_ram
   import sap_pkg::*;
#(
   parameter int ADDR_W         = SAP_ADDR_W,
   parameter int DATA_W         = SAP_DATA_W,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] bus_out,
   input  logic              mar_load_n,
   input  logic              ram_we,
   input  logic              ram_oe_n,
   input  logic              prog_mode,
   input  logic              prog_valid,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_ready,
   output logic              prog_done,
   output logic              busy,
   output logic [ADDR_W-1:0] mar
);

   localparam int               DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH-1);
   localparam sap_state_e       RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

   sap_state_e        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic              done_q, done_d;
   logic              busy_q, ready_q;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   sap_ram_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (mar_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      mar_d     = mar_q;
      done_d    = done_q;
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = prog_data;
      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_wdata = '0;
            if (ptr_q == PTR_LAST) begin
               ptr_d   = '0;
               state_d = prog_mode ? ST_PROG : ST_RUN;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (!mar_load_n) mar_d = bus_in[ADDR_W-1:0];
            // Write uses the pre-edge MAR even when a load happens on the same edge.
            if (ram_we) begin
               mem_we    = 1'b1;
               mem_waddr = mar_q;
               mem_wdata = bus_in;
            end
            if (prog_mode) state_d = ST_PROG;
         end
         ST_PROG: begin
            // Exit edge takes priority and never accepts a word.
            if (!prog_mode) begin
               state_d = ST_RUN;
               ptr_d   = '0;
               done_d  = 1'b0;
            end else if (prog_valid && ready_q) begin
               mem_we = 1'b1;
               ptr_d  = ptr_q + 1'b1;
               if (ptr_q == PTR_LAST) done_d = 1'b1;
            end
         end
         default: begin
            state_d = RST_STATE;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         ptr_q   <= '0;
         mar_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= CLEAR_ON_RESET;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mar_q   <= mar_d;
         done_q  <= done_d;
         busy_q  <= (state_d == ST_CLEAR);
         ready_q <= (state_d == ST_PROG);
      end
   end

   assign bus_out    = (state_q == ST_RUN && !ram_oe_n) ? mem_rdata : {DATA_W{1'bz}};
   assign prog_ready = ready_q;
   assign prog_done  = done_q;
   assign busy       = busy_q;
   assign mar        = mar_q;

endmodule
